// File: rtl/axi4l_if.sv
// AXI4-Lite bundle, 32-bit address and data, shared by the register port and the data mover.
interface axi4l_if (input logic aclk);
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_dma.sv
// Single-channel word copy engine: AXI4-Lite register slave plus a one-word-at-a-time mover master.
module axi4l_dma (
    input  logic    clk,
    input  logic    rst_n,
    output logic    irq,
    axi4l_if.slave  axis,
    axi4l_if.master axim
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, FIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d, dst_q, dst_d;
    logic [31:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [31:0] data_q, data_d, rdata_q, rdata_d;
    logic [15:0] len_q, len_d, remain_q, remain_d;
    logic        irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic        busy, wr_acc, rd_acc, start, aw_hs, w_hs;
    logic [2:0]  wsel, rsel;
    logic        unused_ok;

    assign busy   = (state_q != IDLE);
    // A write needs both AW and W present and no response still waiting.
    assign wr_acc = rst_n & axis.awvalid & axis.wvalid & ~bvalid_q;
    assign rd_acc = rst_n & axis.arvalid & ~rvalid_q;
    assign wsel   = axis.awaddr[4:2];
    assign rsel   = axis.araddr[4:2];
    assign start  = wr_acc & (wsel == 3'd3) & axis.wdata[0] & ~busy;

    assign axis.awready = wr_acc;
    assign axis.wready  = wr_acc;
    assign axis.bvalid  = bvalid_q;
    assign axis.bresp   = 2'b00;
    assign axis.arready = rd_acc;
    assign axis.rvalid  = rvalid_q;
    assign axis.rdata   = rdata_q;
    assign axis.rresp   = 2'b00;

    assign axim.araddr  = cur_src_q;
    assign axim.arprot  = 3'b000;
    assign axim.arvalid = (state_q == RD_A);
    assign axim.rready  = (state_q == RD_D);
    assign axim.awaddr  = cur_dst_q;
    assign axim.awprot  = 3'b000;
    assign axim.awvalid = (state_q == WR_A) & ~aw_done_q;
    assign axim.wdata   = data_q;
    assign axim.wstrb   = 4'hF;
    assign axim.wvalid  = (state_q == WR_A) & ~w_done_q;
    assign axim.bready  = (state_q == WR_B);

    assign aw_hs = axim.awvalid & axim.awready;
    assign w_hs  = axim.wvalid & axim.wready;
    assign irq   = done_q & irq_en_q;

    assign unused_ok = ^{axis.awaddr[31:5], axis.awaddr[1:0], axis.araddr[31:5],
                         axis.araddr[1:0], axis.awprot, axis.arprot, axis.wstrb};

    // Register read path: capture the addressed register on AR acceptance, hold until rready.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        if (rvalid_q && axis.rready) rvalid_d = 1'b0;
        if (rd_acc) begin
            rvalid_d = 1'b1;
            case (rsel)
                3'd0:    rdata_d = src_q;
                3'd1:    rdata_d = dst_q;
                3'd2:    rdata_d = {16'h0, len_q};
                3'd3:    rdata_d = {30'h0, irq_en_q, 1'b0};
                3'd4:    rdata_d = {29'h0, err_q, done_q, busy};
                3'd5:    rdata_d = {16'h0, remain_q};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    // Register writes plus mover FSM next-state; hardware done/err setting is applied last so it wins.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        remain_d  = remain_q;
        data_d    = data_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        bvalid_d  = bvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        if (bvalid_q && axis.bready) bvalid_d = 1'b0;
        if (wr_acc) begin
            bvalid_d = 1'b1;
            case (wsel)
                3'd0: if (!busy) src_d = {axis.wdata[31:2], 2'b00};
                3'd1: if (!busy) dst_d = {axis.wdata[31:2], 2'b00};
                3'd2: if (!busy) len_d = axis.wdata[15:0];
                3'd3: irq_en_d = axis.wdata[1];
                3'd4: begin
                    done_d = done_q & ~axis.wdata[1];
                    err_d  = err_q & ~axis.wdata[2];
                end
                default: ;
            endcase
        end

        case (state_q)
            IDLE: if (start) begin
                cur_src_d = src_q;
                cur_dst_d = dst_q;
                remain_d  = len_q;
                done_d    = 1'b0;
                err_d     = 1'b0;
                state_d   = (len_q == 16'd0) ? FIN : RD_A;
            end
            RD_A: if (axim.arready) state_d = RD_D;
            RD_D: if (axim.rvalid) begin
                data_d = axim.rdata;
                if (axim.rresp != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = WR_A;
                end
            end
            WR_A: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_B;
                end
            end
            WR_B: if (axim.bvalid) begin
                if (axim.bresp != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    remain_d  = remain_q - 16'd1;
                    state_d   = (remain_q == 16'd1) ? FIN : RD_A;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // done is visible during the FIN cycle itself.
        if (state_d == FIN) done_d = 1'b1;
    end

    // Control and register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= 32'h0;
            dst_q     <= 32'h0;
            len_q     <= 16'h0;
            cur_src_q <= 32'h0;
            cur_dst_q <= 32'h0;
            remain_q  <= 16'h0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            remain_q  <= remain_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Data holding registers; only meaningful while their valid is set, so no reset.
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        rdata_q <= rdata_d;
    end
endmodule

// File: tb/tb_axi4l_dma.sv
// Directed bench for axi4l_dma: register-port master tasks and a stallable RAM slave on the mover port.
`timescale 1ns/1ps
module tb_axi4l_dma;
    localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
    localparam logic [31:0] A_CTRL = 32'h0C, A_STAT = 32'h10, A_REM = 32'h14;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;
    always #5 clk = ~clk;

    axi4l_if axis (.aclk(clk));
    axi4l_if axim (.aclk(clk));

    axi4l_dma dut (.clk(clk), .rst_n(rst_n), .irq(irq), .axis(axis.slave), .axim(axim.master));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, viol = 0;
    int stall_max = 0;
    int first_ar_cyc = -1, irq_cyc = -1, acc_cyc = 0;
    logic [31:0] mem [0:1023];

    function automatic int pick();
        if (stall_max == 0) return 0;
        return int'($urandom_range(0, stall_max));
    endfunction

    // RAM slave on the mover port, driven on the falling edge; handshakes are decided per cycle.
    initial begin : responder
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend;
        bit arv_prev, awv_prev, wv_prev;
        int ar_wait, r_wait, aw_wait, w_wait, b_wait;
        logic [31:0] ar_a, aw_a, w_d;
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend} = '0;
        {arv_prev, awv_prev, wv_prev} = '0;
        {ar_wait, r_wait, aw_wait, w_wait, b_wait} = '0;
        ar_a = '0; aw_a = '0; w_d = '0;
        axim.arready = 0; axim.rvalid = 0; axim.rdata = 0; axim.rresp = 0;
        axim.awready = 0; axim.wready = 0; axim.bvalid = 0; axim.bresp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                {ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_got, w_got, b_pend} = '0;
                {arv_prev, awv_prev, wv_prev} = '0;
                {ar_wait, r_wait, aw_wait, w_wait, b_wait} = '0;
                axim.arready = 0; axim.rvalid = 0; axim.awready = 0;
                axim.wready = 0; axim.bvalid = 0;
                continue;
            end
            if ((arv_prev && !axim.arvalid) || (awv_prev && !axim.awvalid) ||
                (wv_prev && !axim.wvalid)) viol++;
            if ((axim.arvalid && r_pend) || (axim.awvalid && b_pend)) viol++;
            if (axim.arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
            if (irq && irq_cyc < 0) irq_cyc = cyc;

            if (ar_hs) begin ar_cnt++; axim.arready = 0; r_pend = 1; r_wait = pick(); ar_wait = pick(); end
            if (r_hs) begin axim.rvalid = 0; r_pend = 0; end
            if (aw_hs) begin aw_cnt++; axim.awready = 0; aw_got = 1; end
            if (w_hs) begin w_cnt++; axim.wready = 0; w_got = 1; end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = pick();
                if (aw_a < 32'h1000) begin mem[aw_a[11:2]] = w_d; axim.bresp = 2'b00; end
                else axim.bresp = 2'b11;
            end
            if (b_hs) begin
                axim.bvalid = 0; b_pend = 0;
                aw_wait = pick();
                w_wait = (stall_max == 0) ? 0 : (aw_wait + 1 + int'($urandom_range(0, 4))) % 6;
            end

            if (r_pend && !axim.rvalid) begin
                if (r_wait == 0) begin
                    axim.rvalid = 1;
                    if (ar_a < 32'h1000) begin axim.rdata = mem[ar_a[11:2]]; axim.rresp = 2'b00; end
                    else begin axim.rdata = 32'h0; axim.rresp = 2'b11; end
                end else r_wait--;
            end
            if (b_pend && !axim.bvalid) begin
                if (b_wait == 0) axim.bvalid = 1; else b_wait--;
            end
            if (axim.arvalid && !axim.arready && !r_pend) begin
                if (ar_wait == 0) axim.arready = 1; else ar_wait--;
            end
            if (axim.awvalid && !axim.awready && !aw_got) begin
                if (aw_wait == 0) axim.awready = 1; else aw_wait--;
            end
            if (axim.wvalid && !axim.wready && !w_got) begin
                if (w_wait == 0) axim.wready = 1; else w_wait--;
            end

            ar_hs = axim.arvalid && axim.arready; if (ar_hs) ar_a = axim.araddr;
            r_hs  = axim.rvalid && axim.rready;
            aw_hs = axim.awvalid && axim.awready; if (aw_hs) aw_a = axim.awaddr;
            w_hs  = axim.wvalid && axim.wready; if (w_hs) w_d = axim.wdata;
            b_hs  = axim.bvalid && axim.bready;
            arv_prev = axim.arvalid && !ar_hs;
            awv_prev = axim.awvalid && !aw_hs;
            wv_prev  = axim.wvalid && !w_hs;
        end
    end

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        axis.awaddr = a; axis.awprot = 0; axis.awvalid = 1;
        axis.wdata = d; axis.wstrb = 4'hF; axis.wvalid = 1;
        #1;
        n = 0;
        while (!(axis.awready && axis.wready) && n < 50) begin @(negedge clk); #1; n++; end
        acc_cyc = cyc;
        if (n >= 50) begin total++; bad++; $display("FAIL wr_accept addr=%h awready=0 required=1", a); end
        @(negedge clk);
        axis.awvalid = 0; axis.wvalid = 0;
        #1;
        n = 0;
        while (!axis.bvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL wr_bvalid addr=%h bvalid=0 required=1", a); end
        resp = axis.bresp;
        axis.bready = 1;
        @(negedge clk);
        axis.bready = 0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        axis.araddr = a; axis.arprot = 0; axis.arvalid = 1;
        #1;
        n = 0;
        while (!axis.arready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL rd_accept addr=%h arready=0 required=1", a); end
        @(negedge clk);
        axis.arvalid = 0;
        #1;
        n = 0;
        while (!axis.rvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL rd_rvalid addr=%h rvalid=0 required=1", a); end
        d = axis.rdata;
        axis.rready = 1;
        @(negedge clk);
        axis.rready = 0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int n = 0;
        reg_read(A_STAT, st);
        while (st[0] && n < 200) begin reg_read(A_STAT, st); n++; end
        if (st[0]) begin total++; bad++; $display("FAIL idle_wait status=%h busy required=0", st); end
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 300) begin @(negedge clk); n++; end
        if (!irq) begin total++; bad++; $display("FAIL irq_wait irq=0 required=1"); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [10:0] outs;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        outs = {axim.arvalid, axim.rready, axim.awvalid, axim.wvalid, axim.bready,
                axis.awready, axis.wready, axis.arready, axis.bvalid, axis.rvalid, irq};
        total++; if (outs !== 11'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", outs); end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            reg_read(32'(i * 4), d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", i, d); end
        end
    endtask

    task automatic test_copy4();
        logic [31:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] d;
        logic [1:0] r;
        int ar0, aw0, w0, start_acc;
        stall_max = 0;
        for (int i = 0; i < 4; i++) begin mem[64 + i] = exp4[i]; mem[128 + i] = 32'h0; end
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        first_ar_cyc = -1; irq_cyc = -1;
        reg_write(A_SRC, 32'h100, r);
        reg_write(A_DST, 32'h200, r);
        reg_write(A_LEN, 32'd4, r);
        reg_write(A_CTRL, 32'h3, r);
        start_acc = acc_cyc;
        wait_irq();
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[128 + i] !== exp4[i]) begin bad++; $display("FAIL copy4_word%0d got=%h exp=%h", i, mem[128 + i], exp4[i]); end
        end
        total++; if (first_ar_cyc != start_acc + 1) begin bad++; $display("FAIL copy4_start_latency got=%0d exp=%0d", first_ar_cyc - start_acc, 1); end
        total++; if (irq_cyc - first_ar_cyc != 16) begin bad++; $display("FAIL copy4_cycles got=%0d exp=16", irq_cyc - first_ar_cyc); end
        reg_read(A_STAT, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL copy4_status got=%h exp=2", d); end
        reg_read(A_REM, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL copy4_remain got=%h exp=0", d); end
        total++; if (ar_cnt - ar0 != 4 || aw_cnt - aw0 != 4 || w_cnt - w0 != 4) begin
            bad++; $display("FAIL copy4_handshakes got ar=%0d aw=%0d w=%0d exp 4 each", ar_cnt - ar0, aw_cnt - aw0, w_cnt - w0);
        end
        reg_write(A_STAT, 32'h2, r);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL copy4_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_len0();
        logic [31:0] d;
        logic [1:0] r;
        int ar0, aw0;
        ar0 = ar_cnt; aw0 = aw_cnt;
        irq_cyc = -1;
        reg_write(A_LEN, 32'd0, r);
        reg_write(A_CTRL, 32'h3, r);
        total++; if (irq_cyc != acc_cyc + 1) begin bad++; $display("FAIL len0_done_latency got=%0d exp=1", irq_cyc - acc_cyc); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL len0_irq got=%b exp=1", irq); end
        total++; if (ar_cnt != ar0 || aw_cnt != aw0) begin bad++; $display("FAIL len0_traffic got ar=%0d aw=%0d exp 0", ar_cnt - ar0, aw_cnt - aw0); end
        reg_read(A_STAT, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL len0_status got=%h exp=2", d); end
        reg_write(A_STAT, 32'h2, r);
    endtask

    task automatic test_decerr();
        logic [31:0] d, st;
        logic [1:0] r;
        int ar0;
        mem[1023] = 32'h0;
        ar0 = ar_cnt;
        reg_write(A_SRC, 32'h100, r);
        reg_write(A_DST, 32'hFFC, r);
        reg_write(A_LEN, 32'd3, r);
        reg_write(A_CTRL, 32'h1, r);
        wait_idle(st);
        total++; if (st !== 32'h6) begin bad++; $display("FAIL decerr_status got=%h exp=6", st); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL decerr_irq_masked got=%b exp=0", irq); end
        reg_read(A_REM, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL decerr_remain got=%h exp=2", d); end
        total++; if (ar_cnt - ar0 != 2) begin bad++; $display("FAIL decerr_ar_count got=%0d exp=2", ar_cnt - ar0); end
        total++; if (mem[1023] !== 32'h11) begin bad++; $display("FAIL decerr_word0 got=%h exp=11", mem[1023]); end
        reg_write(A_STAT, 32'h2, r);
        reg_read(A_STAT, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL w1c_done_only got=%h exp=4", d); end
        reg_write(A_STAT, 32'h4, r);
        reg_read(A_STAT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_err got=%h exp=0", d); end
    endtask

    task automatic test_busy_writes();
        logic [31:0] exp4 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] d, st;
        logic [1:0] r1, r2, r;
        int ar0;
        stall_max = 5;
        for (int i = 0; i < 4; i++) mem[192 + i] = 32'h0;
        reg_write(A_SRC, 32'h100, r);
        reg_write(A_DST, 32'h300, r);
        reg_write(A_LEN, 32'd4, r);
        ar0 = ar_cnt;
        reg_write(A_CTRL, 32'h1, r);
        reg_write(A_SRC, 32'hDEAD, r1);
        reg_write(A_CTRL, 32'h1, r2);
        reg_write(A_LEN, 32'd9, r);
        reg_read(A_STAT, d);
        total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL busy_flag got=%h exp busy=1", d); end
        total++; if (r1 !== 2'b00 || r2 !== 2'b00) begin bad++; $display("FAIL busy_resp got=%b/%b exp=00/00", r1, r2); end
        wait_idle(st);
        total++; if (st !== 32'h2) begin bad++; $display("FAIL busy_status got=%h exp=2", st); end
        reg_read(A_SRC, d);
        total++; if (d !== 32'h100) begin bad++; $display("FAIL busy_src_kept got=%h exp=100", d); end
        reg_read(A_LEN, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL busy_len_kept got=%h exp=4", d); end
        total++; if (ar_cnt - ar0 != 4) begin bad++; $display("FAIL busy_ar_count got=%0d exp=4", ar_cnt - ar0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[192 + i] !== exp4[i]) begin bad++; $display("FAIL busy_word%0d got=%h exp=%h", i, mem[192 + i], exp4[i]); end
        end
        reg_write(A_STAT, 32'h2, r);
    endtask

    task automatic test_stalls();
        logic [31:0] pat [6] = '{32'hCAFE0001, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h5A5AA5A5};
        logic [31:0] d, st;
        logic [1:0] r;
        int ar0, aw0, w0;
        stall_max = 5;
        for (int i = 0; i < 6; i++) begin mem[256 + i] = pat[i]; mem[320 + i] = 32'hEEEEEEEE; end
        reg_write(A_SRC, 32'h403, r);
        reg_write(A_DST, 32'h500, r);
        reg_write(A_LEN, 32'hABCD0006, r);
        reg_read(A_SRC, d);
        total++; if (d !== 32'h400) begin bad++; $display("FAIL src_low_bits got=%h exp=400", d); end
        reg_read(A_LEN, d);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL len_width got=%h exp=6", d); end
        ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
        reg_write(A_CTRL, 32'h1, r);
        wait_idle(st);
        total++; if (st !== 32'h2) begin bad++; $display("FAIL stall_status got=%h exp=2", st); end
        for (int i = 0; i < 6; i++) begin
            total++; if (mem[320 + i] !== pat[i]) begin bad++; $display("FAIL stall_word%0d got=%h exp=%h", i, mem[320 + i], pat[i]); end
        end
        total++; if (ar_cnt - ar0 != 6 || aw_cnt - aw0 != 6 || w_cnt - w0 != 6) begin
            bad++; $display("FAIL stall_handshakes got ar=%0d aw=%0d w=%0d exp 6 each", ar_cnt - ar0, aw_cnt - aw0, w_cnt - w0);
        end
        reg_write(A_STAT, 32'h2, r);
        stall_max = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0] r;
        logic [10:0] outs;
        int n = 0;
        stall_max = 0;
        mem[448] = 32'h0; mem[449] = 32'h0;
        reg_write(A_SRC, 32'h100, r);
        reg_write(A_DST, 32'h600, r);
        reg_write(A_LEN, 32'd2, r);
        reg_write(A_CTRL, 32'h3, r);
        while (!axim.rready && n < 50) begin @(negedge clk); n++; end
        total++; if (!axim.rready) begin bad++; $display("FAIL mid_reach_rd_d rready=0 required=1"); end
        rst_n = 0;
        @(negedge clk);
        #1;
        outs = {axim.arvalid, axim.rready, axim.awvalid, axim.wvalid, axim.bready,
                axis.awready, axis.wready, axis.arready, axis.bvalid, axis.rvalid, irq};
        total++; if (outs !== 11'b0) begin bad++; $display("FAIL mid_reset_outputs got=%b exp=0", outs); end
        @(negedge clk);
        rst_n = 1;
        reg_read(A_STAT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_status got=%h exp=0", d); end
        reg_read(A_SRC, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_src got=%h exp=0", d); end
        reg_write(A_SRC, 32'h100, r);
        reg_write(A_DST, 32'h700, r);
        reg_write(A_LEN, 32'd2, r);
        reg_write(A_CTRL, 32'h3, r);
        wait_irq();
        total++; if (mem[448] !== 32'h11 || mem[449] !== 32'h22) begin
            bad++; $display("FAIL mid_retry_data got=%h,%h exp=11,22", mem[448], mem[449]);
        end
        reg_read(A_STAT, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL mid_retry_status got=%h exp=2", d); end
    endtask

    initial begin
        rst_n = 0;
        axis.awaddr = 0; axis.awprot = 0; axis.awvalid = 0; axis.wdata = 0; axis.wstrb = 0;
        axis.wvalid = 0; axis.bready = 0; axis.araddr = 0; axis.arprot = 0; axis.arvalid = 0;
        axis.rready = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_copy4();
        test_len0();
        test_decerr();
        test_busy_writes();
        test_stalls();
        test_reset_mid();
        total++; if (viol != 0) begin bad++; $display("FAIL axim_protocol got=%0d violations exp=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule

// File: doc/axi4l_dma.md
# axi4l_dma

Single-channel memory-to-memory copy engine for the AXI4-Lite SoC fabric. Software programs it through a register port that is an additional slave on the interconnect. It then moves 32-bit words from a source address to a destination address as an extra master on the same interconnect. It raises a level interrupt on completion, so the SoC can move RAM blocks or poll GPIO into RAM without CPU load/store loops.

## Interface
- No parameters.
- clk  in  1  system clock; also drives aclk of both interfaces.
- rst_n  in  1  reset; synchronous, active-low.
- irq  out  1  completion interrupt; level, equals STATUS.done & CTRL.irq_en.
- axis  axi4l_if slave modport  32-bit addr/data  register port; decodes byte offset bits [4:2].
- axim  axi4l_if master modport  32-bit addr/data  data-mover port.

## Operation
- Register map (word offsets, 32-bit access, wstrb ignored):
  - 0x00 SRC: source byte address; bits [1:0] read 0.
  - 0x04 DST: destination byte address; bits [1:0] read 0.
  - 0x08 LEN: transfer length in words; 16 bits, [31:16] read 0.
  - 0x0C CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (RW).
  - 0x10 STATUS: bit0 busy (RO); bit1 done (W1C); bit2 err (W1C).
  - 0x14 REMAIN: words still to copy (RO).
  - Other offsets read 0, writes ignored. Every access responds OKAY.
- Writes to SRC/DST/LEN while busy are ignored. A start while busy is ignored.
- A start while idle latches SRC, DST and LEN into working registers and clears done and err in the same cycle.
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_B, FIN.
  - IDLE: on start, go to FIN if LEN==0, else to RD_A.
  - RD_A: arvalid=1 with araddr=cur_src and arprot=0. Leave on arready.
  - RD_D: rready=1. On rvalid, capture rdata. If rresp!=OKAY, set err and go to FIN; else go to WR_A.
  - WR_A: awvalid and wvalid both asserted with awaddr=cur_dst, wdata=captured word, wstrb=4'hF, awprot=0. Each valid drops independently after its own handshake. Leave when both channels have handshaken.
  - WR_B: bready=1. On bvalid, if bresp!=OKAY set err and go to FIN. Otherwise cur_src+=4, cur_dst+=4, remain-=1, then go to FIN if remain reaches 0, else to RD_A.
  - FIN: set done, return to IDLE.
- Address increment wraps modulo 2^32.
- busy is 1 in every state except IDLE.
- Only one word is outstanding at a time; there is never more than one AR or AW in flight.
- Register-port slave:
  - AW and W are accepted in the same cycle only when both are valid and no B is pending.
  - AR is accepted only when no R is pending.
  - A simultaneous read and write are both serviced. A write wins over internal done/err setting for W1C only when it occurs in a different cycle; set-by-hardware wins in the same cycle.

## Timing
- Reset values:
  - All axim valids and readys are 0.
  - All axis readys are 0.
  - bvalid and rvalid are 0.
  - irq is 0.
  - SRC, DST, LEN, CTRL, STATUS and REMAIN are 0.
  - FSM is in IDLE.
- Reset mid-transfer aborts immediately without completing the outstanding handshake.
- Register port: bvalid is asserted the cycle after AW/W acceptance. rvalid/rdata are asserted the cycle after AR acceptance. Both are held until the corresponding ready.
- Start-to-arvalid latency: 1 cycle (the start write is accepted in cycle N; arvalid is high in N+1).
- With a zero-wait target, each word takes 4 cycles (RD_A, RD_D, WR_A, WR_B).
- done and irq rise 1 cycle after the final B handshake (the FIN cycle). irq falls the cycle after done is cleared or irq_en is cleared.
- axim valids are never withdrawn before their ready.

## Test plan
- SRC=0x100, DST=0x200, LEN=4, RAM preloaded with 0x11..0x44 -> DST words equal source; STATUS=0x2; REMAIN=0; exactly 4 AR and 4 AW handshakes; 16 cycles from first arvalid to done with zero-wait RAM.
- LEN=0, start -> done the next cycle with no axim traffic; irq=1 when irq_en=1.
- Destination at an unmapped address (interconnect DECERR) on word 2 of 3 -> err=1 and done=1; REMAIN=2; no further AR issued.
- While busy, write SRC=0xDEAD and issue start -> registers and transfer unchanged; both writes get OKAY responses.
- Random ready/valid stalls on axim (arready, rvalid, awready, wready and bvalid delayed 0-5 cycles, with aw/w accepted in different cycles) -> correct data and no duplicate handshakes.
- Assert rst_n=0 in RD_D -> next cycle all outputs are at reset values and the FSM is in IDLE; a subsequent transfer completes normally.
